wb_host_master: RTL and testbench

// - Wishbone classic (B4, non-pipelined) single-transfer initiator: the master-side counterpart of the
//   wbs_* slave port on vsdmemsoc. Drives the same signal set from the master end.
// - Accepts one read/write request on a valid/ready interface, runs a single bus cycle, and returns

---
 rtl/wb_pkg.sv | 24 ++
 rtl/wb_timeout_ctr.sv | 48 ++++
 rtl/wb_host_master.sv | 142 ++++++++++++++
 tb/tb_wb_host_master.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone host master.
// Contents:
//   - WB_AW / WB_DW : default address and data widths
//   - state_e       : master FSM states (IDLE, BUS, RESP)
//   - wb_req_t      : latched request (we, adr, dat, sel)
package wb_pkg;

  localparam int WB_AW = 32;
  localparam int WB_DW = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic                 we;
    logic [WB_AW-1:0]     adr;
    logic [WB_DW-1:0]     dat;
    logic [WB_DW/8-1:0]   sel;
  } wb_req_t;

endpackage

// File: rtl/wb_timeout_ctr.sv
// Ack-wait timeout counter.
// Counts cycles while enabled. tc_o is high during the TO_CYCLES-th enabled
// cycle after a clear, so a bus cycle is aborted after exactly TO_CYCLES
// cycles of cyc/stb. TO_CYCLES = 0 disables the terminal count entirely.
// Ports:
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset
//   clr_i  : restart the count (takes priority over en_i)
//   en_i   : count this cycle
//   tc_o   : terminal count reached
module wb_timeout_ctr #(
  parameter int unsigned TO_CYCLES = 255,
  parameter int unsigned TO_W      = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  // The count is 0 in the first enabled cycle, so the terminal value is one
  // less than the number of cycles to wait.
  localparam logic [TO_W-1:0] TERM = (TO_CYCLES == 0) ? '0 : TO_W'(TO_CYCLES - 1);
  localparam bit              TO_EN = (TO_CYCLES != 0);

  logic [TO_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !tc_o && TO_EN) begin
      cnt_d = cnt_q + TO_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = TO_EN && (cnt_q == TERM);

endmodule

// File: rtl/wb_host_master.sv
// Wishbone classic (B4, non-pipelined) single-transfer initiator.
// Accepts one request on a valid/ready interface, runs one bus cycle, and
// returns read data or a timeout error on a valid/ready response interface.
// Ports:
//   wb_clk_i, wb_rst_ni                  : clock, async active-low reset
//   req_valid/req_ready/req_we/adr/dat/sel : request channel
//   rsp_valid/rsp_ready/rsp_dat/rsp_err    : response channel
//   wbm_cyc_o/stb_o/we_o/sel_o/adr_o/dat_o : Wishbone master outputs
//   wbm_ack_i, wbm_dat_i                   : Wishbone slave returns
//   busy                                   : FSM not in IDLE
module wb_host_master
  import wb_pkg::*;
#(
  parameter int          AW        = WB_AW,
  parameter int          DW        = WB_DW,
  parameter int unsigned TO_CYCLES = 255,
  parameter int unsigned TO_W      = 8
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_ni,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [AW-1:0]   req_adr,
  input  logic [DW-1:0]   req_dat,
  input  logic [DW/8-1:0] req_sel,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [DW-1:0]   rsp_dat,
  output logic            rsp_err,
  output logic            wbm_cyc_o,
  output logic            wbm_stb_o,
  output logic            wbm_we_o,
  output logic [DW/8-1:0] wbm_sel_o,
  output logic [AW-1:0]   wbm_adr_o,
  output logic [DW-1:0]   wbm_dat_o,
  input  logic            wbm_ack_i,
  input  logic [DW-1:0]   wbm_dat_i,
  output logic            busy
);

  // The latched request uses the package struct, so the widths must agree.
  if (AW != WB_AW || DW != WB_DW) begin : g_width_check
    $error("wb_host_master: AW/DW must match wb_pkg WB_AW/WB_DW");
  end
  if ((DW % 8) != 0) begin : g_dw_check
    $error("wb_host_master: DW must be a multiple of 8");
  end

  state_e          state_q;
  wb_req_t         req_q;
  logic            cyc_q;
  logic            req_ready_q;
  logic            rsp_valid_q;
  logic [DW-1:0]   rsp_dat_q;
  logic            rsp_err_q;

  logic            accept;
  logic            to_tc;

  assign accept = (state_q == IDLE) && req_valid;

  wb_timeout_ctr #(
    .TO_CYCLES (TO_CYCLES),
    .TO_W      (TO_W)
  ) u_timeout (
    .clk_i  (wb_clk_i),
    .rst_ni (wb_rst_ni),
    .clr_i  (accept),
    .en_i   (state_q == BUS),
    .tc_o   (to_tc)
  );

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q     <= IDLE;
      req_q       <= '0;
      cyc_q       <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            req_q       <= '{we: req_we, adr: req_adr, dat: req_dat, sel: req_sel};
            cyc_q       <= 1'b1;
            req_ready_q <= 1'b0;
            state_q     <= BUS;
          end
        end
        BUS: begin
          // Ack is checked before the terminal count so a late ack still
          // completes the transfer normally.
          if (wbm_ack_i) begin
            rsp_dat_q   <= req_q.we ? '0 : wbm_dat_i;
            rsp_err_q   <= 1'b0;
            cyc_q       <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else if (to_tc) begin
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b1;
            cyc_q       <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          cyc_q       <= 1'b0;
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_dat   = rsp_dat_q;
  assign rsp_err   = rsp_err_q;

  // Address/data/select/we come only from the latched request and simply
  // hold their last value outside a bus cycle.
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_we_o  = req_q.we;
  assign wbm_adr_o = req_q.adr;
  assign wbm_dat_o = req_q.dat;
  assign wbm_sel_o = req_q.sel;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_wb_host_master.sv
module tb_wb_host_master;
  import wb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [AW-1:0] req_adr = '0;
  logic [DW-1:0] req_dat = '0;
  logic [SW-1:0] req_sel = '0;
  logic          rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [DW-1:0] rsp_dat;
  logic          wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [SW-1:0] wbm_sel_o;
  logic [AW-1:0] wbm_adr_o;
  logic [DW-1:0] wbm_dat_o;
  logic          wbm_ack_i = 1'b0;
  logic [DW-1:0] wbm_dat_i = '0;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;
  logic [AW-1:0] pend_adr = '0;

  wb_host_master #(.AW(AW), .DW(DW), .TO_CYCLES(TO), .TO_W(8)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_adr(req_adr), .req_dat(req_dat), .req_sel(req_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i), .busy(busy)
  );

  // Reference model: a slave that acks on BUS cycle ack_at (0 = never).
  // Without a timely ack the transfer is aborted after TO cycles.
  function automatic bit model_err(input int ack_at);
    return (ack_at == 0) || (TO != 0 && ack_at > TO);
  endfunction
  function automatic int model_cyc(input int ack_at);
    return model_err(ack_at) ? TO : ack_at;
  endfunction
  function automatic logic [DW-1:0] model_dat(input int ack_at, input logic we, input logic [DW-1:0] rdata);
    return (model_err(ack_at) || we) ? '0 : rdata;
  endfunction

  // One transfer; returns observations only, checks are done by callers.
  task automatic run_xfer(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                          input logic [SW-1:0] sel, input int ack_at, input logic [DW-1:0] rdata,
                          input int hold, input bit pend,
                          output int cyc_n, output int lat, output logic [DW-1:0] o_dat,
                          output logic o_err, output bit drive_ok, output bit hold_ok, output bit got_rsp);
    int w;
    cyc_n = 0; lat = 0; o_dat = '0; o_err = 1'b0;
    drive_ok = 1'b1; hold_ok = 1'b1; got_rsp = 1'b0;
    w = 0;
    while (!req_ready && w < 20) begin @(negedge clk); w++; end
    req_valid = 1'b1; req_we = we; req_adr = adr; req_dat = dat; req_sel = sel;
    @(negedge clk);
    // Scramble the request inputs: the bus must use the latched copy.
    req_valid = 1'b0; req_we = ~we; req_adr = $urandom; req_dat = $urandom; req_sel = SW'($urandom);
    for (int k = 1; k <= 50; k++) begin
      if (rsp_valid) begin got_rsp = 1'b1; lat = k; break; end
      if (wbm_cyc_o) begin
        cyc_n++;
        if (!wbm_stb_o || wbm_we_o !== we || wbm_adr_o !== adr || wbm_sel_o !== sel || wbm_dat_o !== dat)
          drive_ok = 1'b0;
      end
      wbm_ack_i = (k == ack_at);
      wbm_dat_i = (k == ack_at) ? rdata : DW'($urandom);
      @(negedge clk);
    end
    wbm_ack_i = 1'b0;
    if (got_rsp) begin
      o_dat = rsp_dat; o_err = rsp_err;
      if (pend) begin req_valid = 1'b1; req_we = 1'b1; req_adr = pend_adr; req_dat = 32'hA5A5_0001; req_sel = 4'hF; end
      for (int h = 0; h < hold; h++) begin
        if (rsp_valid !== 1'b1 || rsp_dat !== o_dat || rsp_err !== o_err || req_ready !== 1'b0 || wbm_cyc_o !== 1'b0)
          hold_ok = 1'b0;
        @(negedge clk);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    $display("[TB] xfer we=%0b adr=%h ack_at=%0d cyc=%0d lat=%0d rsp_dat=%h err=%0b", we, adr, ack_at, cyc_n, lat, o_dat, o_err);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_tests++; if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0) begin n_fail++; $display("FAIL reset_cyc: got cyc=%0b stb=%0b exp 0", wbm_cyc_o, wbm_stb_o); end
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %0b exp 1", req_ready); end
    n_tests++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_dat !== '0) begin n_fail++; $display("FAIL reset_rsp: got v=%0b e=%0b d=%h exp 0", rsp_valid, rsp_err, rsp_dat); end
    n_tests++; if (wbm_adr_o !== '0 || wbm_dat_o !== '0 || wbm_sel_o !== '0 || wbm_we_o !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_bus: got adr=%h dat=%h busy=%0b exp 0", wbm_adr_o, wbm_dat_o, busy); end
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++; if (req_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle: got ready=%0b busy=%0b exp 1/0", req_ready, busy); end
  endtask

  task automatic test_zero_wait_write();
    int c, l; logic [DW-1:0] d; logic e; bit dok, hok, got;
    run_xfer(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 1, 32'h5555_AAAA, 0, 1'b0, c, l, d, e, dok, hok, got);
    n_tests++; if (!got) begin n_fail++; $display("FAIL wr_rsp_seen: got none exp rsp_valid"); end
    n_tests++; if (c !== 1) begin n_fail++; $display("FAIL wr_cyc_len: got %0d exp 1", c); end
    n_tests++; if (!dok) begin n_fail++; $display("FAIL wr_drive: bus outputs differ from request"); end
    n_tests++; if (l !== 2) begin n_fail++; $display("FAIL wr_latency: got %0d exp 2", l); end
    n_tests++; if (e !== 1'b0 || d !== '0) begin n_fail++; $display("FAIL wr_rsp: got err=%0b dat=%h exp 0/0", e, d); end
  endtask

  task automatic test_wait_read();
    int c, l; logic [DW-1:0] d; logic e; bit dok, hok, got;
    run_xfer(1'b0, 32'h3000_0010, 32'h0, 4'hF, 4, 32'h1234_5678, 0, 1'b0, c, l, d, e, dok, hok, got);
    n_tests++; if (c !== 4) begin n_fail++; $display("FAIL rd_cyc_len: got %0d exp 4", c); end
    n_tests++; if (!dok) begin n_fail++; $display("FAIL rd_adr_stable: bus outputs changed during wait"); end
    n_tests++; if (d !== 32'h1234_5678 || e !== 1'b0) begin n_fail++; $display("FAIL rd_rsp: got dat=%h err=%0b exp 12345678/0", d, e); end
    n_tests++; if (l !== 5) begin n_fail++; $display("FAIL rd_latency: got %0d exp 5", l); end
  endtask

  task automatic test_timeout();
    int c, l; logic [DW-1:0] d; logic e; bit dok, hok, got;
    run_xfer(1'b0, 32'h3000_0020, 32'h0, 4'h3, 0, 32'hFFFF_FFFF, 2, 1'b0, c, l, d, e, dok, hok, got);
    n_tests++; if (c !== TO) begin n_fail++; $display("FAIL to_cyc_len: got %0d exp %0d", c, TO); end
    n_tests++; if (e !== 1'b1 || d !== '0) begin n_fail++; $display("FAIL to_rsp: got err=%0b dat=%h exp 1/0", e, d); end
    n_tests++; if (!hok) begin n_fail++; $display("FAIL to_rsp_hold: response not stable"); end
    n_tests++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL to_idle: got v=%0b ready=%0b busy=%0b exp 0/1/0", rsp_valid, req_ready, busy); end
  endtask

  task automatic test_backpressure();
    int c, l; logic [DW-1:0] d; logic e; bit dok, hok, got;
    pend_adr = 32'h3000_0100;
    run_xfer(1'b0, 32'h3000_0040, 32'h0, 4'hF, 2, 32'hCAFE_F00D, 10, 1'b1, c, l, d, e, dok, hok, got);
    n_tests++; if (!hok) begin n_fail++; $display("FAIL bp_hold: rsp not stable or new cycle started while stalled"); end
    n_tests++; if (d !== 32'hCAFE_F00D || e !== 1'b0) begin n_fail++; $display("FAIL bp_rsp: got dat=%h err=%0b exp cafef00d/0", d, e); end
    n_tests++; if (req_ready !== 1'b1 || wbm_cyc_o !== 1'b0) begin n_fail++; $display("FAIL bp_gap: got ready=%0b cyc=%0b exp 1/0", req_ready, wbm_cyc_o); end
    @(negedge clk);
    req_valid = 1'b0;
    n_tests++; if (wbm_cyc_o !== 1'b1 || wbm_adr_o !== pend_adr || wbm_we_o !== 1'b1) begin n_fail++; $display("FAIL bp_pending: got cyc=%0b adr=%h we=%0b exp 1/%h/1", wbm_cyc_o, wbm_adr_o, wbm_we_o, pend_adr); end
    wbm_ack_i = 1'b1;
    @(negedge clk);
    wbm_ack_i = 1'b0;
    n_tests++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_dat !== '0) begin n_fail++; $display("FAIL bp_pending_rsp: got v=%0b e=%0b d=%h exp 1/0/0", rsp_valid, rsp_err, rsp_dat); end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    $display("[TB] xfer pending write adr=%h completed", pend_adr);
  endtask

  task automatic test_async_reset();
    bit no_rsp;
    req_valid = 1'b1; req_we = 1'b0; req_adr = 32'h3000_0080; req_sel = 4'hF;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    n_tests++; if (wbm_cyc_o !== 1'b1) begin n_fail++; $display("FAIL ar_in_bus: got cyc=%0b exp 1", wbm_cyc_o); end
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0) begin n_fail++; $display("FAIL ar_cyc_drop: got cyc=%0b stb=%0b exp 0", wbm_cyc_o, wbm_stb_o); end
    @(negedge clk);
    rst_n = 1'b1;
    no_rsp = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || wbm_cyc_o !== 1'b0) no_rsp = 1'b0;
    end
    n_tests++; if (req_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL ar_idle: got ready=%0b busy=%0b exp 1/0", req_ready, busy); end
    n_tests++; if (!no_rsp) begin n_fail++; $display("FAIL ar_no_rsp: response or cycle after reset"); end
    $display("[TB] xfer aborted by reset adr=%h", 32'h3000_0080);
  endtask

  task automatic test_spurious_ack();
    int c, l; logic [DW-1:0] d; logic e; bit dok, hok, got, quiet;
    quiet = 1'b1;
    wbm_ack_i = 1'b1; wbm_dat_i = 32'hBAD0_BAD0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0 || wbm_cyc_o !== 1'b0) quiet = 1'b0;
    end
    wbm_ack_i = 1'b0;
    n_tests++; if (!quiet) begin n_fail++; $display("FAIL spur_idle: state changed on idle ack"); end
    // Ack in the same cycle as the terminal count.
    run_xfer(1'b0, 32'h3000_00C0, 32'h0, 4'hF, TO, 32'h0F0F_1E1E, 0, 1'b0, c, l, d, e, dok, hok, got);
    n_tests++; if (c !== TO) begin n_fail++; $display("FAIL tc_ack_cyc: got %0d exp %0d", c, TO); end
    n_tests++; if (e !== 1'b0 || d !== 32'h0F0F_1E1E) begin n_fail++; $display("FAIL tc_ack_rsp: got err=%0b dat=%h exp 0/0f0f1e1e", e, d); end
  endtask

  task automatic test_random();
    int c, l, ack_at, hold; logic [DW-1:0] d, wd, rd; logic e, we; logic [AW-1:0] a; logic [SW-1:0] s;
    bit dok, hok, got;
    for (int t = 0; t < 20; t++) begin
      we = 1'(($urandom >> 3) & 1); a = $urandom; wd = $urandom; rd = $urandom; s = SW'($urandom);
      ack_at = int'($urandom_range(0, 6)); hold = int'($urandom_range(0, 3));
      run_xfer(we, a, wd, s, ack_at, rd, hold, 1'b0, c, l, d, e, dok, hok, got);
      n_tests++; if (c !== model_cyc(ack_at) || l !== model_cyc(ack_at) + 1) begin n_fail++; $display("FAIL rnd%0d_timing: got cyc=%0d lat=%0d exp %0d/%0d", t, c, l, model_cyc(ack_at), model_cyc(ack_at) + 1); end
      n_tests++; if (e !== model_err(ack_at)) begin n_fail++; $display("FAIL rnd%0d_err: got %0b exp %0b", t, e, model_err(ack_at)); end
      n_tests++; if (d !== model_dat(ack_at, we, rd)) begin n_fail++; $display("FAIL rnd%0d_dat: got %h exp %h", t, d, model_dat(ack_at, we, rd)); end
      n_tests++; if (!dok || !hok) begin n_fail++; $display("FAIL rnd%0d_stable: got drive=%0b hold=%0b exp 1/1", t, dok, hok); end
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait_write();
    test_wait_read();
    test_timeout();
    test_backpressure();
    test_async_reset();
    test_spurious_ack();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
